// File: rtl/partial_sum_accumulator_pkg.sv
// Shared types and helpers for the partial-sum accumulator.
// The state enum names the two effective modes of the output register.
package partial_sum_accumulator_pkg;

    typedef enum logic {
        ACCUM                     = 1'b0,
        ACCUM_WITH_RESULT_PENDING = 1'b1
    } acc_state_e;

    // Beat counter width; a single-beat group still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/partial_sum_accumulator_lane.sv
// One lane of the accumulator: sign-extends the incoming partial sum,
// adds it to (or loads it into) the running total, and holds the group result.
module partial_sum_accumulator_lane #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 accept,
    input  logic                 first_beat,
    input  logic                 last_beat,
    input  logic [IN_WIDTH-1:0]  data_in,
    output logic [OUT_WIDTH-1:0] data_out
);

    logic signed [OUT_WIDTH-1:0] sext;
    logic signed [OUT_WIDTH-1:0] base;
    logic signed [OUT_WIDTH-1:0] sum;
    logic signed [OUT_WIDTH-1:0] acc;
    logic signed [OUT_WIDTH-1:0] out_reg;

    assign sext = OUT_WIDTH'($signed(data_in));
    // The first beat of a group ignores whatever the previous group left in acc.
    assign base = first_beat ? '0 : acc;
    assign sum  = base + sext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            out_reg <= '0;
        end else if (accept) begin
            if (last_beat) begin
                out_reg <= sum;
            end else begin
                acc <= sum;
            end
        end
    end

    assign data_out = out_reg;

endmodule

// File: rtl/partial_sum_accumulator.sv
// Sums ACC_COUNT consecutive partial-sum beats per lane and presents one
// result vector per group, holding it until the downstream side takes it.
module partial_sum_accumulator
    import partial_sum_accumulator_pkg::*;
#(
    parameter int IN_WIDTH    = 16,
    parameter int PARALLELISM = 4,
    parameter int ACC_COUNT   = 4,
    parameter int OUT_WIDTH   = IN_WIDTH + $clog2(ACC_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  data_in [PARALLELISM],
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [OUT_WIDTH-1:0] data_out [PARALLELISM],
    output logic                 data_out_valid,
    input  logic                 data_out_ready
);

    localparam int CNT_W = cnt_width(ACC_COUNT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_COUNT - 1);

    acc_state_e       state;
    acc_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic             first_beat;
    logic             last_beat;
    logic             accept;
    logic             drain;

    // Handshake: a beat moves when valid && ready on the same posedge, on both
    // sides. Valid never waits on ready; data_out_valid is purely registered.
    assign first_beat     = (cnt == '0);
    assign last_beat      = (cnt == LAST_CNT);
    assign data_out_valid = (state == ACCUM_WITH_RESULT_PENDING);
    assign drain          = data_out_valid && data_out_ready;
    assign data_in_ready  = !(last_beat && data_out_valid && !data_out_ready);
    assign accept         = data_in_valid && data_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= last_beat ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // A new result loading while the old one drains keeps valid high.
    always_comb begin
        state_next = state;
        if (accept && last_beat) begin
            state_next = ACCUM_WITH_RESULT_PENDING;
        end else if (drain) begin
            state_next = ACCUM;
        end
    end

    for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
        partial_sum_accumulator_lane #(
            .IN_WIDTH (IN_WIDTH),
            .OUT_WIDTH(OUT_WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .accept    (accept),
            .first_beat(first_beat),
            .last_beat (last_beat),
            .data_in   (data_in[i]),
            .data_out  (data_out[i])
        );
    end

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Bench for partial_sum_accumulator: a 4-beat instance and a 1-beat instance,
// each checked every cycle against a group-sum model, plus directed scenarios.
module tb_partial_sum_accumulator;

    localparam int IW  = 8;
    localparam int P   = 4;
    localparam int AC  = 4;
    localparam int OW  = 10;
    localparam int OW1 = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [IW-1:0]  din [P];
    logic           din_valid  = 1'b0;
    logic           din_ready;
    logic [OW-1:0]  dout [P];
    logic           dout_valid;
    logic           dout_ready = 1'b1;

    logic [IW-1:0]  din1 [P];
    logic           din1_valid  = 1'b0;
    logic           din1_ready;
    logic [OW1-1:0] dout1 [P];
    logic           dout1_valid;
    logic           dout1_ready = 1'b1;

    partial_sum_accumulator #(
        .IN_WIDTH(IW), .PARALLELISM(P), .ACC_COUNT(AC), .OUT_WIDTH(OW)
    ) dut (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(din_valid), .data_in_ready(din_ready),
        .data_out(dout), .data_out_valid(dout_valid), .data_out_ready(dout_ready)
    );

    partial_sum_accumulator #(
        .IN_WIDTH(IW), .PARALLELISM(P), .ACC_COUNT(1), .OUT_WIDTH(OW1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .data_in(din1), .data_in_valid(din1_valid), .data_in_ready(din1_ready),
        .data_out(dout1), .data_out_valid(dout1_valid), .data_out_ready(dout1_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard: 4-beat instance ----------------
    logic [P*OW-1:0] exp_q[$];
    logic [P*OW-1:0] last_out;
    logic [P*OW-1:0] exp_data;
    logic [P*OW-1:0] res;
    logic            exp_valid;
    int              grp_sum [P];
    int              grp_n;
    int              n_out = 0;

    function automatic logic [P*OW-1:0] pack0();
        logic [P*OW-1:0] v;
        for (int i = 0; i < P; i++) v[i*OW +: OW] = dout[i];
        return v;
    endfunction

    // Outputs compared at negedge; the handshakes seen here are those the next posedge acts on.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            grp_n    = 0;
            last_out = '0;
            for (int i = 0; i < P; i++) grp_sum[i] = 0;
        end else begin
            exp_valid = (exp_q.size() != 0);
            chk("out_valid", dout_valid, exp_valid);
            exp_data = exp_valid ? exp_q[0] : last_out;
            chk("out_data", pack0(), exp_data);
            chk("in_ready", din_ready, !(grp_n == AC - 1 && exp_valid && !dout_ready));
            if (exp_valid && dout_ready) begin
                last_out = exp_q.pop_front();
                n_out++;
            end
            if (din_valid && din_ready) begin
                for (int i = 0; i < P; i++) grp_sum[i] += int'($signed(din[i]));
                grp_n++;
                if (grp_n == AC) begin
                    for (int i = 0; i < P; i++) begin
                        res[i*OW +: OW] = OW'(grp_sum[i]);
                        grp_sum[i] = 0;
                    end
                    exp_q.push_back(res);
                    grp_n = 0;
                end
            end
        end
    end

    // ---------------- scoreboard: 1-beat instance ----------------
    logic [P*OW1-1:0] exp1_q[$];
    logic [P*OW1-1:0] last1;
    logic [P*OW1-1:0] res1;
    logic [P*OW1-1:0] got1;
    logic             exp1_valid;

    always @(negedge clk) begin
        if (rst) begin
            exp1_q.delete();
            last1 = '0;
        end else begin
            for (int i = 0; i < P; i++) got1[i*OW1 +: OW1] = dout1[i];
            exp1_valid = (exp1_q.size() != 0);
            chk("out1_valid", dout1_valid, exp1_valid);
            chk("out1_data", got1, exp1_valid ? exp1_q[0] : last1);
            chk("in1_ready", din1_ready, !(exp1_valid && !dout1_ready));
            if (exp1_valid && dout1_ready) last1 = exp1_q.pop_front();
            if (din1_valid && din1_ready) begin
                for (int i = 0; i < P; i++) res1[i*OW1 +: OW1] = OW1'(int'($signed(din1[i])));
                exp1_q.push_back(res1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_all(input logic [IW-1:0] v);
        for (int i = 0; i < P; i++) din[i] = v;
    endtask

    task automatic push_beat();
        int n = 0;
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("beat_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic push_beat1();
        int n = 0;
        din1_valid = 1'b1;
        @(negedge clk);
        while (!din1_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("beat1_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        din1_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int n0;

    initial begin
        set_all('0);
        for (int i = 0; i < P; i++) din1[i] = '0;
        #2;
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_data0", dout[0], 10'h000);
        chk("rst_ready", din_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Basic sum: lane0 1..4, lane1 10..40
        n0 = n_out;
        for (int k = 1; k <= 4; k++) begin
            din[0] = IW'(k);
            din[1] = IW'(10 * k);
            din[2] = '0;
            din[3] = '0;
            push_beat();
        end
        chk("basic_valid", dout_valid, 1'b1);
        chk("basic_lane0", dout[0], 10'd10);
        chk("basic_lane1", dout[1], 10'd100);
        idle(4);
        chk("basic_one_out", 32'(n_out - n0), 32'd1);

        // Signed extremes
        set_all(8'h80);
        repeat (4) push_beat();
        chk("neg_ext", dout[2], 10'h200);
        set_all(8'h7F);
        repeat (4) push_beat();
        chk("pos_ext", dout[3], 10'h1FC);
        set_all(8'h7F); push_beat();
        set_all(8'h80); push_beat();
        set_all(8'h01); push_beat();
        set_all(8'hFF); push_beat();
        chk("mixed_ext", dout[0], 10'h3FF);
        idle(2);

        // Backpressure: A=8 held, B=12 follows with no bubble
        dout_ready = 1'b0;
        set_all(8'd2);
        repeat (4) push_beat();
        set_all(8'd3);
        repeat (3) push_beat();
        din_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", din_ready, 1'b0);
            chk("bp_hold_a", dout[0], 10'd8);
            @(posedge clk);
            #1;
        end
        dout_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_high", din_ready, 1'b1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        chk("bp_b_valid", dout_valid, 1'b1);
        chk("bp_b_data", dout[0], 10'd12);
        idle(2);

        // Throughput: 16 continuous beats of 1
        n0 = n_out;
        set_all(8'd1);
        din_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("tput_ready", din_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        idle(3);
        chk("tput_outputs", 32'(n_out - n0), 32'd4);

        // Reset mid-group with a result held
        dout_ready = 1'b0;
        set_all(8'd7);
        repeat (4) push_beat();
        set_all(8'd5);
        repeat (2) push_beat();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", dout_valid, 1'b0);
        chk("mid_rst_data", dout[0], 10'h000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dout_ready = 1'b1;
        set_all(8'd1);
        repeat (4) push_beat();
        chk("post_rst_sum", dout[1], 10'd4);
        idle(2);

        // Single-beat groups
        for (int i = 0; i < P; i++) din1[i] = 8'hFD;
        push_beat1();
        chk("ac1_neg_valid", dout1_valid, 1'b1);
        chk("ac1_neg", dout1[0], 8'hFD);
        for (int i = 0; i < P; i++) din1[i] = 8'd7;
        push_beat1();
        chk("ac1_pos", dout1[2], 8'd7);
        idle(2);

        // Randomized traffic on both instances
        for (int c = 0; c < 600; c++) begin
            din_valid   = ($urandom_range(0, 3) != 0);
            dout_ready  = ($urandom_range(0, 2) != 0);
            din1_valid  = ($urandom_range(0, 1) != 0);
            dout1_ready = ($urandom_range(0, 1) != 0);
            for (int i = 0; i < P; i++) begin
                din[i]  = IW'($urandom_range(0, 255));
                din1[i] = IW'($urandom_range(0, 255));
            end
            @(posedge clk);
            #1;
        end
        din_valid   = 1'b0;
        din1_valid  = 1'b0;
        dout_ready  = 1'b1;
        dout1_ready = 1'b1;
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
